// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared encodings for the UART transmit framer: parity_mode
//               values, FSM state type and small parity decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // parity_mode encodings; 11 behaves exactly like 00
    localparam logic [1:0] c_parity_none     = 2'b00;
    localparam logic [1:0] c_parity_even     = 2'b01;
    localparam logic [1:0] c_parity_odd      = 2'b10;
    localparam logic [1:0] c_parity_none_alt = 2'b11;

    // Transmit FSM states; each state names the bit kind the next tick emits
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } tx_state_t;

    // True when the mode inserts a parity bit after the data bits
    function automatic logic parity_enabled(input logic [1:0] mode);
        logic en;
        case (mode)
            c_parity_even,
            c_parity_odd:      en = 1'b1;
            c_parity_none,
            c_parity_none_alt: en = 1'b0;
            default:           en = 1'b0;
        endcase
        return en;
    endfunction

    // True when the parity bit is the inverse of the data XOR
    function automatic logic parity_is_odd(input logic [1:0] mode);
        return (mode == c_parity_odd);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Small synchronous FIFO feeding the UART transmit framer.
//               Pushes while full and pops while empty are ignored; full and
//               empty are decoded from a registered occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int                c_aw    = $clog2(FIFO_DEPTH);
    localparam int                c_cw    = c_aw + 1;
    localparam logic [c_cw-1:0]   c_depth = c_cw'(FIFO_DEPTH);
    localparam logic [c_cw-1:0]   c_one   = c_cw'(1);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_cw-1:0]   r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign full   = (r_count == c_depth);
    assign empty  = (r_count == '0);
    assign dout   = r_mem[r_rd_ptr];

    // Storage array: written on accepted pushes only, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : uart_tx_fifo
`default_nettype wire

// File: rtl/uart_tx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_framer
// Description : FIFO-buffered UART transmitter. Frames are start bit, DATA_W
//               data bits LSB first, optional parity, one or two stop bits.
//               Framing options are captured when a frame starts so that
//               mid-frame changes only affect the next frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic              tx,
    output logic              tx_busy,
    output logic              full,
    output logic              ovf
);

    localparam int               c_bcw      = $clog2(DATA_W);
    localparam logic [c_bcw-1:0] c_last_bit = c_bcw'(DATA_W - 1);
    localparam logic [c_bcw-1:0] c_bit_one  = c_bcw'(1);

    tx_state_t         r_state,    w_state_nxt;
    logic [c_bcw-1:0]  r_bit_cnt,  w_bit_cnt_nxt;
    logic              r_stop_cnt, w_stop_cnt_nxt;
    logic [DATA_W-1:0] r_shift,    w_shift_nxt;
    logic              r_par,      w_par_nxt;
    logic              r_par_en,   w_par_en_nxt;
    logic              r_par_odd,  w_par_odd_nxt;
    logic              r_stop2,    w_stop2_nxt;
    logic              r_tx,       w_tx_nxt;
    logic              r_ovf;

    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [DATA_W-1:0] w_head;

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (w_pop),
        .din   (data),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign tx      = r_tx;
    assign full    = w_full;
    assign ovf     = r_ovf;
    assign tx_busy = (r_state != IDLE) | ~w_empty;

    // State register and line flop; reset parks the line high immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_stop2    <= 1'b0;
            r_tx       <= 1'b1;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_odd  <= w_par_odd_nxt;
            r_stop2    <= w_stop2_nxt;
            r_tx       <= w_tx_nxt;
            r_ovf      <= wr_en & w_full;
        end
    end

    // Next-state logic; every transition and line change is gated by clk_en.
    // The last stop-bit tick returns to IDLE, whose next tick starts the
    // following frame, so queued words go out back to back with no gap.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_shift_nxt    = r_shift;
        w_par_nxt      = r_par;
        w_par_en_nxt   = r_par_en;
        w_par_odd_nxt  = r_par_odd;
        w_stop2_nxt    = r_stop2;
        w_tx_nxt       = r_tx;
        w_pop          = 1'b0;

        case (r_state)
            IDLE: begin
                if (clk_en) begin
                    if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_shift_nxt   = w_head;
                        w_par_nxt     = 1'b0;
                        w_bit_cnt_nxt = '0;
                        w_par_en_nxt  = parity_enabled(parity_mode);
                        w_par_odd_nxt = parity_is_odd(parity_mode);
                        w_stop2_nxt   = stop2;
                        w_tx_nxt      = 1'b0;
                        w_state_nxt   = DATA;
                    end else begin
                        w_tx_nxt      = 1'b1;
                    end
                end
            end
            DATA: begin
                if (clk_en) begin
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                    w_par_nxt   = r_par ^ r_shift[0];
                    if (r_bit_cnt == c_last_bit) begin
                        w_stop_cnt_nxt = 1'b0;
                        w_state_nxt    = r_par_en ? PARITY : STOP;
                    end else begin
                        w_bit_cnt_nxt  = r_bit_cnt + c_bit_one;
                    end
                end
            end
            PARITY: begin
                if (clk_en) begin
                    w_tx_nxt       = r_par ^ r_par_odd;
                    w_stop_cnt_nxt = 1'b0;
                    w_state_nxt    = STOP;
                end
            end
            STOP: begin
                if (clk_en) begin
                    w_tx_nxt = 1'b1;
                    if (r_stop_cnt == r_stop2) begin
                        w_state_nxt    = IDLE;
                    end else begin
                        w_stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule : uart_tx_framer
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_framer
// Description : Self-checking bench for uart_tx_framer. A queue-based model
//               of words and line bits is compared every cycle against the
//               8-bit instance; directed frames are also pinned to
//               hand-computed bit patterns, including a 5-bit instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_framer;

    localparam int DW       = 8;
    localparam int DEPTH    = 4;
    localparam int TICK_DIV = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en = 1'b0;
    logic       wr_en;
    logic       wr_en5;
    logic [7:0] data;
    logic [4:0] data5;
    logic [1:0] parity_mode;
    logic       stop2;
    logic       tx, tx_busy, full, ovf;
    logic       tx5, tx_busy5, full5, ovf5;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_framer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .wr_en(wr_en), .data(data),
        .parity_mode(parity_mode), .stop2(stop2),
        .tx(tx), .tx_busy(tx_busy), .full(full), .ovf(ovf)
    );

    uart_tx_framer #(.DATA_W(5), .FIFO_DEPTH(DEPTH)) dut5 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .wr_en(wr_en5), .data(data5),
        .parity_mode(parity_mode), .stop2(stop2),
        .tx(tx5), .tx_busy(tx_busy5), .full(full5), .ovf(ovf5)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Baud tick generator: one clk_en pulse every TICK_DIV clocks while enabled
    bit tick_on = 1'b0;
    int tick_cnt = 0;
    always @(negedge clk) begin
        if (tick_on) begin
            if (tick_cnt == TICK_DIV - 1) begin
                tick_cnt = 0;
                clk_en   = 1'b1;
            end else begin
                tick_cnt++;
                clk_en   = 1'b0;
            end
        end else begin
            tick_cnt = 0;
            clk_en   = 1'b0;
        end
    end

    // Reference model: queue of accepted words and queue of pending line bits
    logic [7:0] wq[$];
    bit         bq[$];
    logic       m_tx  = 1'b1;
    logic       m_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wq.delete();
            bq.delete();
            m_tx  = 1'b1;
            m_ovf = 1'b0;
        end else begin
            bit         acc;
            logic [7:0] w;
            acc   = wr_en && (wq.size() < DEPTH);
            m_ovf = wr_en && (wq.size() >= DEPTH);
            if (clk_en) begin
                if (bq.size() == 0 && wq.size() != 0) begin
                    w = wq.pop_front();
                    bq.push_back(1'b0);
                    for (int i = 0; i < DW; i++) bq.push_back(w[i]);
                    if (parity_mode == 2'b01) bq.push_back(^w);
                    else if (parity_mode == 2'b10) bq.push_back(~^w);
                    bq.push_back(1'b1);
                    if (stop2) bq.push_back(1'b1);
                end
                if (bq.size() != 0) m_tx = bq.pop_front();
                else m_tx = 1'b1;
            end
            if (acc) wq.push_back(data);
        end
    end

    // Per-cycle comparison of the 8-bit instance against the model
    bit chk_on = 1'b0;
    always @(negedge clk) begin
        if (chk_on) begin
            check("model_tx",      tx,      m_tx);
            check("model_tx_busy", tx_busy, (bq.size() != 0) || (wq.size() != 0));
            check("model_full",    full,    wq.size() == DEPTH);
            check("model_ovf",     ovf,     m_ovf);
        end
    end

    int ovf_pulses = 0;
    always @(negedge clk) begin
        if (ovf) ovf_pulses++;
    end

    // Wait for the next baud tick (bounded) and sample both lines after it
    task automatic next_tick(output logic txv, output logic tx5v);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 4 * TICK_DIV && !ok; k++) begin
            @(posedge clk);
            if (clk_en) ok = 1'b1;
        end
        #1;
        txv  = tx;
        tx5v = tx5;
        if (!ok) check("tick_timeout", 64'd0, 64'd1);
    endtask

    task automatic capture(input int n, output logic [63:0] v, output logic [63:0] v5);
        logic a, b;
        v  = '0;
        v5 = '0;
        for (int i = 0; i < n; i++) begin
            next_tick(a, b);
            v[i]  = a;
            v5[i] = b;
        end
    endtask

    task automatic write8(input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        data  = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] v, v5, va, vb, dummy;
        rst = 1'b1; wr_en = 1'b0; wr_en5 = 1'b0; data = '0; data5 = '0;
        parity_mode = 2'b00; stop2 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tx",       tx,       1'b1);
        check("rst_tx_busy",  tx_busy,  1'b0);
        check("rst_full",     full,     1'b0);
        check("rst_ovf",      ovf,      1'b0);
        check("rst_tx5",      tx5,      1'b1);
        check("rst_tx_busy5", tx_busy5, 1'b0);
        rst = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);

        // 0x55, no parity, one stop bit
        write8(8'h55);
        check("busy_after_write", tx_busy, 1'b1);
        tick_on = 1'b1;
        capture(10, v, v5);
        check("frame_55", v[9:0], 10'h2AA);
        check("busy_after_frame_55", tx_busy, 1'b0);
        capture(1, v, v5);
        check("idle_after_55", v[0], 1'b1);
        tick_on = 1'b0;

        // 0x07 even parity then odd parity
        parity_mode = 2'b01;
        write8(8'h07);
        tick_on = 1'b1;
        capture(11, v, v5);
        check("frame_07_even", v[10:0], 11'h60E);
        check("busy_after_07_even", tx_busy, 1'b0);
        tick_on = 1'b0;
        parity_mode = 2'b10;
        write8(8'h07);
        tick_on = 1'b1;
        capture(11, v, v5);
        check("frame_07_odd", v[10:0], 11'h40E);
        check("busy_after_07_odd", tx_busy, 1'b0);
        tick_on = 1'b0;

        // 0xA3 odd parity, two stop bits, stop2 toggled mid-frame
        stop2 = 1'b1;
        write8(8'hA3);
        tick_on = 1'b1;
        capture(5, va, v5);
        stop2 = 1'b0;
        capture(7, vb, v5);
        check("frame_A3_stop2", {vb[6:0], va[4:0]}, 12'hF46);
        check("busy_after_A3", tx_busy, 1'b0);
        tick_on = 1'b0;

        // Five writes into a four-deep FIFO, then back-to-back frames
        parity_mode = 2'b00;
        @(negedge clk);
        ovf_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            data  = 8'(i + 1);
            @(negedge clk);
        end
        wr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ovf_pulse_count", ovf_pulses, 1);
        check("full_after_burst", full, 1'b1);
        tick_on = 1'b1;
        capture(40, v, v5);
        check("burst_frame0", v[9:0],   10'h202);
        check("burst_frame1", v[19:10], 10'h204);
        check("burst_frame2", v[29:20], 10'h206);
        check("burst_frame3", v[39:30], 10'h208);
        check("busy_after_burst", tx_busy, 1'b0);
        tick_on = 1'b0;

        // Reset mid-frame with words queued
        write8(8'h00);
        write8(8'h00);
        write8(8'h00);
        tick_on = 1'b1;
        capture(4, v, v5);
        check("tx_low_before_rst", tx, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_mid_tx",      tx,      1'b1);
        check("rst_mid_tx_busy", tx_busy, 1'b0);
        check("rst_mid_full",    full,    1'b0);
        @(negedge clk);
        rst = 1'b0;
        capture(12, v, v5);
        check("no_frames_after_rst", v[11:0], 12'hFFF);
        check("busy_after_rst", tx_busy, 1'b0);
        tick_on = 1'b0;

        // 5-bit instance: 0x1F with even parity
        parity_mode = 2'b01;
        @(negedge clk);
        wr_en5 = 1'b1;
        data5  = 5'h1F;
        @(negedge clk);
        wr_en5 = 1'b0;
        check("busy5_after_write", tx_busy5, 1'b1);
        tick_on = 1'b1;
        capture(8, dummy, v5);
        check("frame5_1F_even", v5[7:0], 8'hFE);
        check("busy5_after_frame", tx_busy5, 1'b0);
        tick_on = 1'b0;

        repeat (2) @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_framer
`default_nettype wire
